vote_round_ctrl: RTL
====================

Name: vote_round_ctrl

Overview:
- Sequential controller around a 5-input majority decision.
- Opens a voting round, collects one vote bit per voter over valid/ready handshakes, and closes on all-voted or timeout.
- Computes the majority over the votes received and presents the result on a valid/ready output channel.
- Sits between redundant producers (replicated checkers/channels) and the consumer of the voted decision.

Parameters:
- N_VOTERS, 5, number of voters; legal range 3..15.
- TIMEOUT, 16, max cycles a round stays in COLLECT; must be >= 1.
- CNT_W, $clog2(N_VOTERS+1), width of vote-count outputs (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse opening a round; honoured only in IDLE.
- busy  out  1  high in any state except IDLE.
- vote_valid  in  N_VOTERS  per-voter vote offered.
- vote_data  in  N_VOTERS  per-voter vote bit.
- vote_ready  out  N_VOTERS  per-voter accept.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  1  majority decision.
- res_timeout  out  1  round closed by timeout, not by all voters voting.
- res_count  out  CNT_W  number of votes received this round.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. Assertion forces IDLE immediately and clears all outputs and internal registers to 0, including mid-round. Any partial round is discarded and no result is emitted.
- States: IDLE, COLLECT, DECIDE, RESULT.
- IDLE: start=1 -> COLLECT. Clear the received mask, vote register and timer.
- COLLECT:
  - vote_ready[i] = 1 iff voter i has not yet voted this round.
  - On vote_valid[i] & vote_ready[i], capture vote_data[i] and set received[i].
  - Any number of voters may be accepted in the same cycle.
  - A second vote from the same voter is never accepted; its ready stays 0 until the next round.
  - Timer increments every COLLECT cycle.
  - Exit to DECIDE when the received mask, including this cycle's accepts, is all ones, or when the timer equals TIMEOUT-1. Votes accepted on the exit cycle count.
  - All-voted and timeout in the same cycle: res_timeout=0.
- DECIDE (one cycle):
  - vote_ready = 0.
  - ones = popcount(votes & received); zeros = popcount(~votes & received).
  - res_data = (ones > zeros). A tie or zero votes gives 0.
  - res_count = ones + zeros.
  - res_timeout = 1 iff the mask is not full.
  - Register all of these, then go to RESULT.
- RESULT:
  - res_valid = 1. res_data, res_timeout and res_count are held stable until res_valid & res_ready.
  - On handshake -> IDLE; res_valid drops the next cycle.
- start outside IDLE is ignored, including in the RESULT handshake cycle.
- Latency: last vote accepted in cycle k -> res_valid high in cycle k+2. Minimum round is start to res_valid in 3 cycles.
- Outputs are registered except vote_ready, which is a decode of state and mask.
- With N_VOTERS=5 and all votes present, res_data equals the strict 5-input majority.

Optional Feature:
- Macro: VOTE_DISAGREE_EN.
- When defined:
  - Adds output res_disagree [N_VOTERS], registered in DECIDE.
  - Bit i = received[i] & (vote[i] != res_data).
  - Valid and held with res_valid; 0 in reset and IDLE.
  - Used for faulty-replica isolation.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package vote_pkg holds:
  - state enum (IDLE, COLLECT, DECIDE, RESULT);
  - count-width helper function;
  - default N_VOTERS/TIMEOUT constants.
- One sub-module, vote_tally: purely combinational; takes votes and the received mask; returns ones, zeros, decision and the full flag. It is instantiated in DECIDE.

Test Plan:
- All 5 vote 1,1,0,1,0 in one cycle after start -> DECIDE next cycle; res_valid 2 cycles after accept; res_data=1, res_count=5, res_timeout=0.
- Staggered votes, one per cycle; voter 2 holds vote_valid after its accept -> vote_ready[2]=0, the second offer is ignored, res_count=5.
- Only voters 0,1 vote (1,0); TIMEOUT=16 -> COLLECT exits after 16 cycles; res_data=0 (tie), res_count=2, res_timeout=1.
- No votes, TIMEOUT=4 -> res_data=0, res_count=0, res_timeout=1 at start+6.
- res_ready held low 10 cycles with start pulsed during RESULT -> outputs stable; start ignored; IDLE after the handshake.
- rst_n low mid-COLLECT with 3 votes in -> immediate IDLE, all outputs 0, no res_valid. Next round behaves cleanly. With VOTE_DISAGREE_EN, votes 1,1,1,0,0 give res_disagree=5'b11000.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the voting-round controller.
package vote_pkg;

   localparam int unsigned DEF_N_VOTERS = 5;
   localparam int unsigned DEF_TIMEOUT  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DECIDE  = 2'd2,
      RESULT  = 2'd3
   } state_t;

   // Bits needed to hold a vote count in the range 0..n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vote_tally.sv
// Combinational tally of the received votes: counts, majority decision, full flag.
module vote_tally
   import vote_pkg::*;
#(
   parameter  int unsigned N_VOTERS = DEF_N_VOTERS,
   localparam int unsigned CNT_W    = cnt_width(N_VOTERS)
) (
   input  logic [N_VOTERS-1:0] votes,
   input  logic [N_VOTERS-1:0] received,
   output logic [CNT_W-1:0]    ones,
   output logic [CNT_W-1:0]    zeros,
   output logic                decision,
   output logic                full
);

   // Count ones and zeros among voters that actually voted; ties resolve to 0.
   always_comb begin
      ones  = '0;
      zeros = '0;
      for (int i = 0; i < int'(N_VOTERS); i++) begin
         if (received[i]) begin
            if (votes[i]) ones  = ones  + CNT_W'(1);
            else          zeros = zeros + CNT_W'(1);
         end
      end
      decision = (ones > zeros);
      full     = &received;
   end

endmodule

// File: rtl/vote_round_ctrl.sv
// Voting-round controller: collects one vote per voter over valid/ready,
// closes on all-voted or timeout, and presents the majority on a valid/ready
// result channel. Optional per-voter disagreement output under VOTE_DISAGREE_EN.
module vote_round_ctrl
   import vote_pkg::*;
#(
   parameter  int unsigned N_VOTERS = DEF_N_VOTERS,
   parameter  int unsigned TIMEOUT  = DEF_TIMEOUT,
   localparam int unsigned CNT_W    = cnt_width(N_VOTERS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   output logic                busy,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_data,
   output logic [N_VOTERS-1:0] vote_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_data,
   output logic                res_timeout,
`ifdef VOTE_DISAGREE_EN
   output logic [N_VOTERS-1:0] res_disagree,
`endif
   output logic [CNT_W-1:0]    res_count
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   state_t               state, state_next;
   logic [N_VOTERS-1:0]  received, received_next;
   logic [N_VOTERS-1:0]  votes, votes_next;
   logic [N_VOTERS-1:0]  accept;
   logic [TW-1:0]        timer, timer_next;
   logic                 busy_next, res_valid_next, res_data_next, res_timeout_next;
   logic [CNT_W-1:0]     res_count_next;
   logic [CNT_W-1:0]     ones, zeros;
   logic                 decision, full;
`ifdef VOTE_DISAGREE_EN
   logic [N_VOTERS-1:0]  res_disagree_next;
`endif

   vote_tally #(.N_VOTERS(N_VOTERS)) u_tally (
      .votes    (votes),
      .received (received),
      .ones     (ones),
      .zeros    (zeros),
      .decision (decision),
      .full     (full)
   );

   // Next-state, vote capture and next values of the registered outputs.
   always_comb begin
      state_next       = state;
      received_next    = received;
      votes_next       = votes;
      timer_next       = timer;
      accept           = '0;
      vote_ready       = '0;
      res_valid_next   = res_valid;
      res_data_next    = res_data;
      res_timeout_next = res_timeout;
      res_count_next   = res_count;
`ifdef VOTE_DISAGREE_EN
      res_disagree_next = res_disagree;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next    = COLLECT;
               received_next = '0;
               votes_next    = '0;
               timer_next    = '0;
            end
         end
         COLLECT: begin
            vote_ready    = ~received;
            accept        = vote_valid & ~received;
            received_next = received | accept;
            votes_next    = (votes & ~accept) | (vote_data & accept);
            timer_next    = timer + TW'(1);
            if ((&received_next) || (timer == TW'(TIMEOUT - 1))) begin
               state_next = DECIDE;
            end
         end
         DECIDE: begin
            res_valid_next   = 1'b1;
            res_data_next    = decision;
            res_count_next   = ones + zeros;
            res_timeout_next = ~full;
`ifdef VOTE_DISAGREE_EN
            res_disagree_next = received & (votes ^ {N_VOTERS{decision}});
`endif
            state_next = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               state_next       = IDLE;
               res_valid_next   = 1'b0;
               res_data_next    = 1'b0;
               res_count_next   = '0;
               res_timeout_next = 1'b0;
`ifdef VOTE_DISAGREE_EN
               res_disagree_next = '0;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   // State, round registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         received    <= '0;
         votes       <= '0;
         timer       <= '0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= 1'b0;
         res_timeout <= 1'b0;
         res_count   <= '0;
`ifdef VOTE_DISAGREE_EN
         res_disagree <= '0;
`endif
      end else begin
         state       <= state_next;
         received    <= received_next;
         votes       <= votes_next;
         timer       <= timer_next;
         busy        <= busy_next;
         res_valid   <= res_valid_next;
         res_data    <= res_data_next;
         res_timeout <= res_timeout_next;
         res_count   <= res_count_next;
`ifdef VOTE_DISAGREE_EN
         res_disagree <= res_disagree_next;
`endif
      end
   end

endmodule
